// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the multi-channel pulse timer.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    PM_PERIODIC = 2'b00,
    PM_ONESHOT  = 2'b01,
    PM_BURST    = 2'b10,
    PM_RSVD     = 2'b11
  } pulse_mode_e;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } pulse_state_e;

  // The reserved encoding behaves exactly like free-running periodic mode.
  function automatic pulse_mode_e decode_mode(input logic [1:0] raw);
    pulse_mode_e m;
    m = pulse_mode_e'(raw);
    return (m == PM_RSVD) ? PM_PERIODIC : m;
  endfunction

endpackage

// File: rtl/pulse_channel.sv
// One timer channel: IDLE/RUN FSM, latched parameters, phase and period counters.
module pulse_channel
  import pulse_gen_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [1:0]       mode_i,
  input  logic [SIZE-1:0]  period_i,
  input  logic [SIZE-1:0]  width_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o
);

  pulse_state_e     state_q, state_d;
  logic [SIZE-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             pulse_q, pulse_d;
  logic             done_q, done_d;
  logic             load;

  pulse_mode_e      mode_q;
  logic [SIZE-1:0]  period_q;
  logic [SIZE-1:0]  width_q;
  logic [CNT_W-1:0] count_q;

  logic [SIZE-1:0]  peff;
  logic [CNT_W-1:0] neff;
  logic [SIZE-1:0]  phase_inc;
  logic [CNT_W-1:0] pcnt_inc;
  logic [SIZE-1:0]  phase_nxt;
  logic             wrap;
  logic             last;

  // Period and count of zero behave as one.
  assign peff      = (period_q == '0) ? SIZE'(1) : period_q;
  assign neff      = (count_q == '0) ? CNT_W'(1) : count_q;
  assign phase_inc = phase_q + SIZE'(1);
  assign pcnt_inc  = pcnt_q + CNT_W'(1);
  assign wrap      = (phase_inc >= peff);
  assign phase_nxt = wrap ? '0 : phase_inc;
  assign last      = wrap && ((mode_q == PM_ONESHOT) ||
                              ((mode_q == PM_BURST) && (pcnt_inc >= neff)));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pcnt_d  = pcnt_q;
    pulse_d = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    if (stop_i) begin
      // Abort wins over a coincident start; silent in IDLE.
      state_d = CH_IDLE;
      phase_d = '0;
      pcnt_d  = '0;
    end else if (start_i) begin
      load    = 1'b1;
      state_d = CH_RUN;
      phase_d = '0;
      pcnt_d  = '0;
      pulse_d = (width_i != '0);
    end else if (state_q == CH_RUN) begin
      if (last) begin
        state_d = CH_IDLE;
        phase_d = '0;
        pcnt_d  = '0;
        done_d  = 1'b1;
      end else begin
        phase_d = phase_nxt;
        pcnt_d  = (wrap && (mode_q == PM_BURST)) ? pcnt_inc : pcnt_q;
        pulse_d = (phase_nxt < width_q);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CH_IDLE;
      phase_q <= '0;
      pcnt_q  <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pcnt_q  <= pcnt_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  // Shadow copies are only read while running, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (load) begin
      mode_q   <= decode_mode(mode_i);
      period_q <= period_i;
      width_q  <= width_i;
      count_q  <= count_i;
    end
  end

  assign pulse_o = pulse_q;
  assign busy_o  = (state_q == CH_RUN);
  assign done_o  = done_q;

endmodule

// File: rtl/pulse_timer_array.sv
// NUM_CH independent programmable pulse channels sharing a clock and reset.
module pulse_timer_array
  import pulse_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SIZE   = 8,
  parameter int CNT_W  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH-1:0]       start_i,
  input  logic [NUM_CH-1:0]       stop_i,
  input  logic [2*NUM_CH-1:0]     mode_i,
  input  logic [SIZE*NUM_CH-1:0]  period_i,
  input  logic [SIZE*NUM_CH-1:0]  width_i,
  input  logic [CNT_W*NUM_CH-1:0] count_i,
  output logic [NUM_CH-1:0]       pulse_o,
  output logic [NUM_CH-1:0]       busy_o,
  output logic [NUM_CH-1:0]       done_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pulse_channel #(
      .SIZE (SIZE),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_i[c]),
      .stop_i  (stop_i[c]),
      .mode_i  (mode_i[2*c +: 2]),
      .period_i(period_i[SIZE*c +: SIZE]),
      .width_i (width_i[SIZE*c +: SIZE]),
      .count_i (count_i[CNT_W*c +: CNT_W]),
      .pulse_o (pulse_o[c]),
      .busy_o  (busy_o[c]),
      .done_o  (done_o[c])
    );
  end

endmodule

// File: tb/tb_pulse_timer_array.sv
// Directed bench for pulse_timer_array with a per-cycle expectation scoreboard.
module tb_pulse_timer_array;

  logic        clk_i;
  logic        rst_i;
  logic [3:0]  start_i;
  logic [3:0]  stop_i;
  logic [7:0]  mode_i;
  logic [31:0] period_i;
  logic [31:0] width_i;
  logic [31:0] count_i;
  logic [3:0]  pulse_o;
  logic [3:0]  busy_o;
  logic [3:0]  done_o;

  typedef struct packed {
    logic [3:0] p;
    logic [3:0] b;
    logic [3:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  pulse_timer_array #(.NUM_CH(4), .SIZE(8), .CNT_W(8)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .stop_i  (stop_i),
    .mode_i  (mode_i),
    .period_i(period_i),
    .width_i (width_i),
    .count_i (count_i),
    .pulse_o (pulse_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [3:0] v(input int c, input bit val);
    return val ? (4'b0001 << c) : 4'b0000;
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic setch(input int c, input logic [1:0] m, input logic [7:0] per,
                       input logic [7:0] w, input logic [7:0] cnt);
    mode_i[2*c +: 2]   = m;
    period_i[8*c +: 8] = per;
    width_i[8*c +: 8]  = w;
    count_i[8*c +: 8]  = cnt;
  endtask

  // Queue the expectation for the coming edge, clock it, then retire it.
  task automatic cyc(input string tag, input logic [3:0] p, input logic [3:0] b,
                     input logic [3:0] d);
    exp_t e;
    sb.push_back('{p: p, b: b, d: d});
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    check({tag, "_pulse"}, pulse_o, e.p);
    check({tag, "_busy"},  busy_o,  e.b);
    check({tag, "_done"},  done_o,  e.d);
    start_i = '0;
    stop_i  = '0;
  endtask

  initial begin
    rst_i = 1'b1; start_i = '0; stop_i = '0;
    mode_i = '0; period_i = '0; width_i = '0; count_i = '0;
    #3;
    check("rst_pulse", pulse_o, 4'b0000);
    check("rst_busy",  busy_o,  4'b0000);
    check("rst_done",  done_o,  4'b0000);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;

    // async reset mid-run
    setch(0, 2'b00, 8'd5, 8'd2, 8'd0);
    start_i = 4'b0001;
    cyc("pre_rst0", v(0,1), v(0,1), 4'b0);
    cyc("pre_rst1", v(0,1), v(0,1), 4'b0);
    cyc("pre_rst2", 4'b0,   v(0,1), 4'b0);
    #2; rst_i = 1'b1; #1;
    check("async_rst_pulse", pulse_o, 4'b0000);
    check("async_rst_busy",  busy_o,  4'b0000);
    check("async_rst_done",  done_o,  4'b0000);
    #1; rst_i = 1'b0;
    cyc("post_rst", 4'b0, 4'b0, 4'b0);

    // periodic ch0: 1,1,0,0,0 then stop
    setch(0, 2'b00, 8'd5, 8'd2, 8'd0);
    start_i = 4'b0001;
    for (int k = 0; k < 12; k++) cyc("per0", v(0, (k % 5) < 2), v(0,1), 4'b0);
    stop_i = 4'b0001;
    cyc("per0_stop", 4'b0, 4'b0, 4'b0);
    cyc("per0_idle", 4'b0, 4'b0, 4'b0);

    // burst ch1: three pulses spaced 4 apart, 12 busy cycles, then done
    setch(1, 2'b10, 8'd4, 8'd1, 8'd3);
    start_i = 4'b0010;
    for (int k = 0; k < 12; k++) cyc("burst1", v(1, (k % 4) == 0), v(1,1), 4'b0);
    cyc("burst1_end",  4'b0, 4'b0, v(1,1));
    cyc("burst1_idle", 4'b0, 4'b0, 4'b0);

    // one-shot ch2 with period 0, width 1 then width 0
    setch(2, 2'b01, 8'd0, 8'd1, 8'd0);
    start_i = 4'b0100;
    cyc("os2_run",  v(2,1), v(2,1), 4'b0);
    cyc("os2_end",  4'b0,   4'b0,   v(2,1));
    cyc("os2_idle", 4'b0,   4'b0,   4'b0);
    setch(2, 2'b01, 8'd0, 8'd0, 8'd0);
    start_i = 4'b0100;
    cyc("os2w0_run", 4'b0, v(2,1), 4'b0);
    cyc("os2w0_end", 4'b0, 4'b0,   v(2,1));

    // ch3 width boundaries and mid-run parameter changes
    setch(3, 2'b00, 8'd6, 8'd6, 8'd0);
    start_i = 4'b1000;
    for (int k = 0; k < 14; k++) cyc("w_eq_p3", v(3,1), v(3,1), 4'b0);
    setch(3, 2'b00, 8'd3, 8'd255, 8'd0);
    start_i = 4'b1000;
    for (int k = 0; k < 9; k++) cyc("w_max3", v(3,1), v(3,1), 4'b0);
    setch(3, 2'b11, 8'd5, 8'd2, 8'd0);
    start_i = 4'b1000;
    for (int k = 0; k < 15; k++) begin
      if (k == 3) setch(3, 2'b01, 8'd2, 8'd4, 8'd1);
      cyc("rsvd_live3", v(3, (k % 5) < 2), v(3,1), 4'b0);
    end
    stop_i = 4'b1000;
    cyc("stop3", 4'b0, 4'b0, 4'b0);

    // start and stop together in IDLE
    setch(1, 2'b00, 8'd4, 8'd2, 8'd0);
    start_i = 4'b0010; stop_i = 4'b0010;
    cyc("ss_idle0", 4'b0, 4'b0, 4'b0);
    cyc("ss_idle1", 4'b0, 4'b0, 4'b0);

    // restart on the terminating edge of a burst
    setch(1, 2'b10, 8'd2, 8'd1, 8'd2);
    start_i = 4'b0010;
    for (int k = 0; k < 4; k++) cyc("bst_rs", v(1, (k % 2) == 0), v(1,1), 4'b0);
    setch(1, 2'b01, 8'd3, 8'd2, 8'd0);
    start_i = 4'b0010;
    cyc("restart_edge", v(1,1), v(1,1), 4'b0);
    cyc("restart_k1",   v(1,1), v(1,1), 4'b0);
    cyc("restart_k2",   4'b0,   v(1,1), 4'b0);
    cyc("restart_end",  4'b0,   4'b0,   v(1,1));
    cyc("restart_idle", 4'b0,   4'b0,   4'b0);

    // simultaneous independent starts on ch0 and ch3
    setch(0, 2'b00, 8'd3, 8'd1, 8'd0);
    setch(3, 2'b10, 8'd4, 8'd3, 8'd2);
    start_i = 4'b1001;
    for (int k = 0; k < 11; k++) begin
      logic [3:0] ep, eb, ed;
      ep = v(0, (k % 3) == 0) | v(3, (k < 8) && ((k % 4) < 3));
      eb = v(0, 1) | v(3, k < 8);
      ed = v(3, k == 8);
      cyc("dual", ep, eb, ed);
    end
    stop_i = 4'b0001;
    cyc("dual_stop", 4'b0, 4'b0, 4'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_timer_array.md
Name: pulse_timer_array

Overview:
Multi-channel successor to the single-channel tick pulse generator. Each of NUM_CH independent channels produces a programmable waveform on its own output bit. The period and high-width are set per channel. Three modes are supported: free-running periodic, one-shot, and counted burst. Channels have start/stop control and busy/done status. The block sits beside the peripheral timers and drives strobes, PWM-like enables and timed triggers into downstream logic.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
SIZE, 8, width of the period and width counters, in clock cycles
CNT_W, 8, width of the burst pulse count

Ports:
clk_i  in  1  clock; all state is updated on the rising edge
rst_i  in  1  asynchronous active-high reset
start_i  in  NUM_CH  per-channel start strobe; parameters are latched when it is sampled high
stop_i  in  NUM_CH  per-channel abort strobe
mode_i  in  2*NUM_CH  per-channel mode; channel c uses bits [2c+1:2c]
period_i  in  SIZE*NUM_CH  per-channel period in cycles; channel c uses slice [SIZE*c +: SIZE]
width_i  in  SIZE*NUM_CH  per-channel high time in cycles
count_i  in  CNT_W*NUM_CH  per-channel number of periods in burst mode
pulse_o  out  NUM_CH  registered waveform output
busy_o  out  NUM_CH  high while the channel is running
done_o  out  NUM_CH  one-cycle strobe when a one-shot or burst completes

Behaviour:
- Reset is asynchronous and active-high. On reset, every channel goes to IDLE, all counters clear, and pulse_o, busy_o and done_o are 0.
- Mode encoding:
  - 2'b00 PERIODIC: runs until stopped.
  - 2'b01 ONESHOT: exactly one period.
  - 2'b10 BURST: count_i periods.
  - 2'b11 is reserved and decodes as PERIODIC.
- Per-channel FSM has two states, IDLE and RUN.
- IDLE -> RUN on the edge where start_i[c]=1 and stop_i[c]=0. On that edge:
  - mode, period, width and count are latched into shadow registers.
  - The phase counter is set to 0 and the period counter to 0.
  - busy_o=1 and pulse_o=(width>0). The output is high in the first cycle after start is sampled, so latency is 1.
- Live inputs are ignored while in RUN; only the latched copies are used. Changing period_i mid-run has no effect.
- Phase counter (SIZE bits) counts 0..Peff-1 and then wraps to 0. Peff = max(period,1), so period 0 and period 1 both give a 1-cycle period.
- pulse_o is registered and equals (phase < width) for the phase being entered:
  - width=0 keeps the output low for the whole run.
  - width>=Peff keeps the output constant high while running.
- Each wrap of the phase counter ends one period. The period counter (CNT_W bits) increments at each wrap. Neff = max(count,1).
- Termination:
  - ONESHOT ends at the first wrap.
  - BURST ends when the completed period count reaches Neff.
  - On the terminating edge, state -> IDLE, pulse_o=0, busy_o=0, done_o=1 for exactly one cycle.
  - PERIODIC never terminates on its own; the period counter is held at 0 in this mode.
- stop_i[c] in RUN: on the next edge the channel goes to IDLE, pulse_o=0, busy_o=0, and done_o stays 0. stop_i in IDLE has no effect.
- stop_i and start_i high on the same edge: stop wins, and the channel ends in IDLE.
- start_i in RUN (without stop) restarts the channel: new parameters are latched, counters return to 0, and no done strobe is issued.
- start_i on the same edge as natural termination also restarts: busy stays 1 and done_o=0.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Arithmetic is unsigned. Phase comparison is done at SIZE bits and period comparison at CNT_W bits, with no overflow beyond those widths. Because phase stays below Peff, which is at most 2^SIZE-1, it never wraps outside its range.

Decomposition:
- pulse_gen_pkg contains:
  - typedef enum logic [1:0] pulse_mode_e {PM_PERIODIC, PM_ONESHOT, PM_BURST, PM_RSVD}
  - typedef enum logic {CH_IDLE, CH_RUN} pulse_state_e
  - a function that decodes PM_RSVD to PM_PERIODIC.
- One sub-module, pulse_channel: a single channel holding its FSM, shadow registers and both counters. The top level unpacks the port vectors and instantiates NUM_CH copies of it in a generate loop.

Test Plan:
1. Reset: assert rst_i mid-run with no clock edge -> pulse_o, busy_o and done_o go to 0 immediately. After release, all channels are idle.
2. PERIODIC on ch0 with period=5, width=2 -> pulse_o[0] repeats 1,1,0,0,0 starting the cycle after start. Assert stop after 12 cycles -> output low and busy low on the next cycle, done stays 0.
3. BURST on ch1 with period=4, width=1, count=3 -> three high cycles spaced 4 apart. busy_o is high for 12 cycles, then done_o[1] pulses for one cycle as busy drops.
4. ONESHOT on ch2 with period=0, width=1 -> pulse_o high for 1 cycle, busy 1 cycle, done 1 cycle later. Repeat with width=0 -> pulse_o stays 0 and done still fires.
5. Widths at the boundary on ch3: width=period=6 gives constant high. width=255 with period=3 gives constant high. Changing period_i mid-run does not change the waveform.
6. Simultaneous events:
   - start+stop in IDLE -> stays idle.
   - start during BURST at the terminating edge -> restart, no done.
   - start on ch0 and ch3 in the same cycle -> independent waveforms, each matching its own model.
